// File: rtl/jelly_ring_bus_pkg.sv
// rtl/jelly_ring_bus_pkg.sv - shared ring-bus FSM encodings, width defaults and index helper
package jelly_ring_bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } inject_state_t;

  localparam int RING_ID_TO_WIDTH = 2;
  localparam int RING_DATA_WIDTH  = 32;

  // Next round-robin start position after index value, wrapping at n.
  function automatic int wrap_inc(input int value, input int n);
    return (value >= n - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/jelly_ring_bus_rr_select.sv
// rtl/jelly_ring_bus_rr_select.sv - combinational round-robin search from ptr upward modulo N
module jelly_ring_bus_rr_select
  import jelly_ring_bus_pkg::*;
#(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [N-1:0]         request,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] index
);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] rotated;

  // Rotating a doubled copy puts request[ptr] at bit 0, so priority is a plain low-to-high scan.
  assign doubled = {request, request};
  assign rotated = doubled >> ptr;

  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    index = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) begin
        k = k - N;
      end
      if (!found && rotated[i]) begin
        found = 1'b1;
        index = SEL_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/jelly_ring_bus_inject_arbiter.sv
// rtl/jelly_ring_bus_inject_arbiter.sv - ring-bus injection arbiter; burst limit via JELLY_RING_BUS_INJECT_ARBITER_BURST_LIMIT_EN
module jelly_ring_bus_inject_arbiter
  import jelly_ring_bus_pkg::*;
#(
  parameter int N           = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int ID_TO_WIDTH = RING_ID_TO_WIDTH,
  parameter int DATA_WIDTH  = RING_DATA_WIDTH,
  parameter int MAX_BURST   = 16,
  parameter int BURST_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cke,

  input  logic [N*ID_TO_WIDTH-1:0]    s_id_to,
  input  logic [N*DATA_WIDTH-1:0]     s_data,
  input  logic [N-1:0]                s_last,
  input  logic [N-1:0]                s_valid,
  output logic [N-1:0]                s_ready,

  output logic [SEL_WIDTH-1:0]        m_sel,
  output logic [ID_TO_WIDTH-1:0]      m_id_to,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready
);

  inject_state_t          state;
  logic [SEL_WIDTH-1:0]   ptr;
  logic [SEL_WIDTH-1:0]   grant;
  logic                   found;
  logic [SEL_WIDTH-1:0]   found_index;

  logic                   out_free;
  logic                   accept;
  logic                   release_grant;
  logic                   sel_valid;
  logic                   sel_last;
  logic [ID_TO_WIDTH-1:0] sel_id_to;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Illegal parameter combinations elaborate this marker block.
  if (N < 1 || N > (1 << SEL_WIDTH) || MAX_BURST < 1 || MAX_BURST >= (1 << BURST_WIDTH)) begin : g_invalid_config
  end

  jelly_ring_bus_rr_select #(
    .N         (N),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_select (
    .request (s_valid),
    .ptr     (ptr),
    .found   (found),
    .index   (found_index)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = cke & (~m_valid | m_ready);

  always_comb begin
    s_ready   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_id_to = '0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        sel_valid  = s_valid[i];
        sel_last   = s_last[i];
        sel_id_to  = s_id_to[i*ID_TO_WIDTH +: ID_TO_WIDTH];
        sel_data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        s_ready[i] = (state == ST_BUSY) & out_free;
      end
    end
  end

  assign accept = (state == ST_BUSY) & out_free & sel_valid;

`ifdef JELLY_RING_BUS_INJECT_ARBITER_BURST_LIMIT_EN
  logic [BURST_WIDTH-1:0] burst_count;
  logic [BURST_WIDTH-1:0] burst_next;

  assign burst_next    = burst_count + BURST_WIDTH'(1);
  assign release_grant = sel_last | (burst_next == BURST_WIDTH'(MAX_BURST));

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_count <= '0;
    end else if (cke) begin
      if (state == ST_IDLE && found) begin
        burst_count <= '0;
      end else if (accept) begin
        burst_count <= burst_next;
      end
    end
  end
`else
  assign release_grant = sel_last;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_sel   <= '0;
      m_id_to <= '0;
      m_data  <= '0;
    end else if (cke) begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= found_index;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Releasing always passes through IDLE, so every regrant costs one cycle.
          if (accept && release_grant) begin
            state <= ST_IDLE;
            ptr   <= SEL_WIDTH'(wrap_inc(int'(grant), N));
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        m_id_to <= sel_id_to;
        m_data  <= sel_data;
        m_last  <= sel_last;
        m_sel   <= grant;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly_ring_bus_inject_arbiter.sv
// tb/tb_jelly_ring_bus_inject_arbiter.sv - vector table, directed corners and randomized scoreboard for the injection arbiter
`timescale 1ns/1ps
module tb_jelly_ring_bus_inject_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int IW = 2;
  localparam int DW = 32;
  localparam int BW = 5;
`ifdef JELLY_RING_BUS_INJECT_ARBITER_BURST_LIMIT_EN
  localparam int MB = 4;
  localparam bit BURST_LIM = 1'b1;
`else
  localparam int MB = 16;
  localparam bit BURST_LIM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            cke;
  logic [N*IW-1:0] s_id_to;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [SW-1:0]   m_sel;
  logic [IW-1:0]   m_id_to;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jelly_ring_bus_inject_arbiter #(
    .N(N), .SEL_WIDTH(SW), .ID_TO_WIDTH(IW), .DATA_WIDTH(DW), .MAX_BURST(MB), .BURST_WIDTH(BW)
  ) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .s_id_to(s_id_to), .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
    .m_sel(m_sel), .m_id_to(m_id_to), .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] beat;
    logic        mready;
    logic        cke;
    logic        emv;
    logic [1:0]  esel;
    logic [3:0]  ebeat;
    logic        elast;
    logic [3:0]  erdy;
  } vec_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  vec_t  tab[$];
  beat_t sendq[N][$];
  beat_t expq[N][$];
  int    sel_log[$];
  int    cyc_log[$];

  function automatic logic [DW-1:0] tdata(input int i, input int b);
    return DW'(32'hD000_0000 + i * 256 + b);
  endfunction

  function automatic logic [IW-1:0] tid(input int i);
    return IW'(3 - i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic [3:0] v, input logic [3:0] l, input logic [15:0] b,
                     input logic mr, input logic ck, input logic emv, input logic [1:0] es,
                     input logic [3:0] eb, input logic el, input logic [3:0] er);
    vec_t t;
    t.valid = v; t.last = l; t.beat = b; t.mready = mr; t.cke = ck;
    t.emv = emv; t.esel = es; t.ebeat = eb; t.elast = el; t.erdy = er;
    tab.push_back(t);
  endtask

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      s_data[i*DW +: DW]  = tdata(i, int'(v.beat[4*i +: 4]));
      s_id_to[i*IW +: IW] = tid(i);
    end
    s_valid = v.valid;
    s_last  = v.last;
    m_ready = v.mready;
    cke     = v.cke;
  endtask

  task automatic do_reset();
    reset = 1'b1; cke = 1'b1; m_ready = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0; s_id_to = '0;
    for (int i = 0; i < N; i++) begin
      sendq[i].delete();
      expq[i].delete();
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic add_packet(input int i, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.id   = IW'($urandom);
      bt.data = DW'($urandom);
      bt.last = (b == len - 1);
      sendq[i].push_back(bt);
      expq[i].push_back(bt);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += expq[i].size();
    return s;
  endfunction

  // Scoreboard: per-requester order preserved, nothing lost or duplicated, packets not interleaved.
  task automatic run_stream(input int vp, input int rp, input int cp, input int maxc);
    int    cyc = 0;
    bit    in_pkt = 1'b0;
    int    cur = 0;
    int    gb = 0;
    beat_t e;
    sel_log.delete();
    cyc_log.delete();
    while (pending() > 0 && cyc < maxc) begin
      for (int i = 0; i < N; i++) begin
        if (sendq[i].size() > 0 && $urandom_range(99) < vp) begin
          s_valid[i]          = 1'b1;
          s_last[i]           = sendq[i][0].last;
          s_data[i*DW +: DW]  = sendq[i][0].data;
          s_id_to[i*IW +: IW] = sendq[i][0].id;
        end else begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
        end
      end
      m_ready = ($urandom_range(99) < rp);
      cke     = ($urandom_range(99) < cp);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && s_ready[i]) void'(sendq[i].pop_front());
      end
      if (m_valid && m_ready && cke) begin
        if (expq[m_sel].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL stream_extra_beat: got sel=%0d data=%h, expected no beat", m_sel, m_data);
        end else begin
          e = expq[m_sel].pop_front();
          check("stream_beat", {m_id_to, m_data, m_last}, {e.id, e.data, e.last});
        end
        check("stream_no_interleave", (in_pkt && int'(m_sel) != cur), 0);
        gb     = in_pkt ? gb + 1 : 1;
        cur    = int'(m_sel);
        in_pkt = !m_last && !(BURST_LIM && gb == MB);
        sel_log.push_back(int'(m_sel));
        cyc_log.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = '0; s_last = '0; cke = 1'b1; m_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Priority scan with two requesters, then back-pressure, then clock-enable freeze.
    row(4'b0101, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);
    row(4'b0101, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0001);
    row(4'b0101, 4'b0000, 16'h0001, 1, 1, 1, 0, 0, 0, 4'b0001);
    row(4'b0101, 4'b0001, 16'h0002, 1, 1, 1, 0, 1, 0, 4'b0001);
    row(4'b0100, 4'b0000, 16'h0000, 1, 1, 1, 0, 2, 1, 4'b0000);
    row(4'b0100, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0100);
    row(4'b0100, 4'b0000, 16'h0100, 1, 1, 1, 2, 0, 0, 4'b0100);
    row(4'b0100, 4'b0100, 16'h0200, 1, 1, 1, 2, 1, 0, 4'b0100);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 1, 2, 2, 1, 4'b0000);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);
    row(4'b0010, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);
    row(4'b0010, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0010);
    row(4'b0010, 4'b0000, 16'h0010, 1, 1, 1, 1, 0, 0, 4'b0010);
    repeat (3) row(4'b0010, 4'b0000, 16'h0020, 0, 1, 1, 1, 1, 0, 4'b0000);
    row(4'b0010, 4'b0000, 16'h0020, 1, 1, 1, 1, 1, 0, 4'b0010);
    row(4'b0010, 4'b0010, 16'h0030, 1, 1, 1, 1, 2, 0, 4'b0010);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 1, 1, 3, 1, 4'b0000);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);
    row(4'b1000, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);
    row(4'b1000, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b1000);
    row(4'b1000, 4'b0000, 16'h1000, 1, 1, 1, 3, 0, 0, 4'b1000);
    repeat (5) row(4'b1000, 4'b0000, 16'h2000, 1, 0, 1, 3, 1, 0, 4'b0000);
    row(4'b1000, 4'b0000, 16'h2000, 1, 1, 1, 3, 1, 0, 4'b1000);
    row(4'b1000, 4'b1000, 16'h3000, 1, 1, 1, 3, 2, 0, 4'b1000);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 1, 3, 3, 1, 4'b0000);
    row(4'b0000, 4'b0000, 16'h0000, 1, 1, 0, 0, 0, 0, 4'b0000);

    do_reset();
    s_valid = 4'hF; cke = 1'b0;
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_sel", m_sel, 0);
    check("reset_s_ready", s_ready, 0);
    @(posedge clk); #1;
    s_valid = '0; cke = 1'b1;

    foreach (tab[r]) begin
      drive_vec(tab[r]);
      @(negedge clk);
      check($sformatf("tab%0d_m_valid", r), m_valid, tab[r].emv);
      check($sformatf("tab%0d_s_ready", r), s_ready, tab[r].erdy);
      if (tab[r].emv)
        check($sformatf("tab%0d_m_beat", r), {m_sel, m_id_to, m_data, m_last},
              {tab[r].esel, tid(int'(tab[r].esel)), tdata(int'(tab[r].esel), int'(tab[r].ebeat)), tab[r].elast});
      @(posedge clk); #1;
    end
    s_valid = '0; s_last = '0;

    // Every requester with back-to-back single-beat packets: strict rotation, two cycles per beat.
    do_reset();
    for (int i = 0; i < N; i++) repeat (2) add_packet(i, 1);
    run_stream(100, 100, 100, 200);
    check("rr_beats_seen", sel_log.size() >= 5, 1);
    if (sel_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_order%0d", k), sel_log[k], k % N);
        if (k > 0) check($sformatf("rr_spacing%0d", k), cyc_log[k] - cyc_log[k-1], 2);
      end
    end

`ifdef JELLY_RING_BUS_INJECT_ARBITER_BURST_LIMIT_EN
    do_reset();
    add_packet(1, 10);
    add_packet(3, 2);
    run_stream(100, 100, 100, 300);
    begin
      int exp_sel[$] = '{1, 1, 1, 1, 3, 3, 1, 1, 1, 1, 1, 1};
      check("burst_beats", sel_log.size(), exp_sel.size());
      foreach (exp_sel[k])
        if (k < sel_log.size()) check($sformatf("burst_sel%0d", k), sel_log[k], exp_sel[k]);
    end
`endif

    // Reset in the middle of a 5-beat packet, with cke low to show reset still wins.
    do_reset();
    begin
      int b = 0;
      bit hit = 1'b0;
      bit got = 1'b0;
      int gsel = 0;
      logic [DW-1:0] gdata = '0;
      for (int c = 0; c < 40 && !hit; c++) begin
        s_valid = 4'b0010;
        s_data[DW +: DW] = tdata(1, b);
        s_id_to[IW +: IW] = tid(1);
        s_last = {2'b00, (b == 4), 1'b0};
        @(negedge clk);
        if (s_valid[1] && s_ready[1]) b++;
        if (m_valid && m_data == tdata(1, 1)) hit = 1'b1;
        @(posedge clk); #1;
      end
      check("rst_mid_reached", hit, 1);
      reset = 1'b1; cke = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_mid_m_valid", m_valid, 0);
      check("rst_mid_s_ready", s_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0; cke = 1'b1;
      for (int i = 0; i < N; i++) begin
        s_data[i*DW +: DW]  = tdata(i, 7);
        s_id_to[i*IW +: IW] = tid(i);
      end
      s_valid = 4'b1011; s_last = 4'b1111;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (m_valid) begin
          got = 1'b1;
          gsel = int'(m_sel);
          gdata = m_data;
        end
        @(posedge clk); #1;
      end
      check("rst_after_beat_seen", got, 1);
      check("rst_after_winner", gsel, 0);
      check("rst_after_data", gdata, tdata(0, 7));
      s_valid = '0; s_last = '0;
    end

    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 5; p++) add_packet(i, $urandom_range(1, 6));
    run_stream(75, 70, 90, 4000);
    for (int i = 0; i < N; i++) check($sformatf("rand_drained%0d", i), expq[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
